cdc_rx_packetizer: RTL and testbench

//  Buffers bytes received by the local UART (valid-only, no backpressure) and presents them as a

---
 rtl/hflink_stream_pkg.sv | 17 +
 rtl/stream_fifo_ram.sv | 30 +++
 rtl/cdc_rx_packetizer.sv | 143 ++++++++++++++
 tb/tb_cdc_rx_packetizer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hflink_stream_pkg.sv
// rtl/hflink_stream_pkg.sv - shared constants and helpers for host-link byte streams
package hflink_stream_pkg;

    localparam int BYTE_W         = 8;
    localparam int CDC_PKT_MAX_FS = 64;
    localparam int CDC_PKT_MAX_HS = 512;
    localparam int CDC_IDLE_CYC   = 4000;
    localparam int OVF_CNT_W      = 16;

    typedef logic [BYTE_W-1:0]    byte_t;
    typedef logic [OVF_CNT_W-1:0] ovf_cnt_t;

    function automatic ovf_cnt_t sat_inc(input ovf_cnt_t v);
        return (v == '1) ? v : v + ovf_cnt_t'(1);
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// rtl/stream_fifo_ram.sv - simple dual-port RAM, one write port, one registered read port
module stream_fifo_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cdc_rx_packetizer.sv
// rtl/cdc_rx_packetizer.sv - UART rx bytes to valid/ready stream with tlast at PKT_MAX or idle timeout
module cdc_rx_packetizer
    import hflink_stream_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int PKT_MAX  = CDC_PKT_MAX_FS,
    parameter int IDLE_CYC = CDC_IDLE_CYC
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 clr,
    input  logic                 s_tvalid,
    input  logic [BYTE_W-1:0]    s_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [BYTE_W-1:0]    m_tdata,
    output logic                 m_tlast,
    output logic [ADDR_W:0]      level,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = ADDR_W + 1;
    localparam int PW    = (PKT_MAX > 2) ? $clog2(PKT_MAX) : 1;
    localparam int TW    = $clog2(IDLE_CYC + 1);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     r_ram_cnt;
    logic [LW-1:0]     r_flush_cnt;
    logic [PW-1:0]     r_pkt_cnt;
    logic [TW-1:0]     r_idle;
    ovf_cnt_t          r_ovf_cnt;
    logic              r_rd_valid;
    logic              r_m_tvalid;
    byte_t             r_m_tdata;

    logic  w_full;
    logic  w_wr;
    logic  w_pop;
    logic  w_load;
    logic  w_rd;
    logic  w_tlast;
    logic  w_idle_hit;
    byte_t w_rd_data;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_wr    = s_tvalid & ~w_full;
    assign w_pop   = r_m_tvalid & m_tready;
    // Read stage feeds the output register whenever it is empty or being emptied.
    assign w_load  = r_rd_valid & (~r_m_tvalid | w_pop);
    assign w_rd    = (r_ram_cnt != '0) & (~r_rd_valid | w_load);
    assign w_tlast = r_m_tvalid & ((r_pkt_cnt == PW'(PKT_MAX - 1)) | (r_flush_cnt == LW'(1)));
    // A write in the same cycle restarts the timer, so the hit never coincides with one.
    assign w_idle_hit = ~w_wr & (r_idle == TW'(IDLE_CYC - 1));

    stream_fifo_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (BYTE_W)
    ) u_ram (
        .i_clk     (hclk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wptr),
        .i_wr_data (s_tdata),
        .i_rd_en   (w_rd),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_ram_cnt   <= '0;
            r_flush_cnt <= '0;
            r_pkt_cnt   <= '0;
            r_idle      <= '0;
            r_ovf_cnt   <= '0;
            r_rd_valid  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
        end else if (clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_ram_cnt   <= '0;
            r_flush_cnt <= '0;
            r_pkt_cnt   <= '0;
            r_idle      <= '0;
            r_ovf_cnt   <= '0;
            r_rd_valid  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            r_ram_cnt <= r_ram_cnt + LW'(w_wr) - LW'(w_rd);
            r_level   <= r_level + LW'(w_wr) - LW'(w_pop);

            if (s_tvalid & w_full) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end

            r_rd_valid <= w_rd | (r_rd_valid & ~w_load);
            if (w_load) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_rd_data;
            end else if (w_pop) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_wr) begin
                r_idle <= '0;
            end else if (r_idle != TW'(IDLE_CYC)) begin
                r_idle <= r_idle + TW'(1);
            end

            // The byte leaving this cycle is excluded from the latched flush length.
            if (w_idle_hit && (r_flush_cnt == '0) && (r_level != '0)) begin
                r_flush_cnt <= r_level - LW'(w_pop);
            end else if (w_pop && (r_flush_cnt != '0)) begin
                r_flush_cnt <= r_flush_cnt - LW'(1);
            end

            if (w_pop) begin
                r_pkt_cnt <= w_tlast ? '0 : r_pkt_cnt + PW'(1);
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tlast  = w_tlast;
    assign level    = r_level;
    assign ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_cdc_rx_packetizer.sv
// tb/tb_cdc_rx_packetizer.sv - directed self-checking bench for cdc_rx_packetizer
module tb_cdc_rx_packetizer;

    logic        hclk;
    logic        hresetn;
    logic        clr;
    logic        s_tvalid;
    logic [7:0]  s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic [9:0]  level;
    logic [15:0] ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] q[$];

    cdc_rx_packetizer #(
        .ADDR_W   (9),
        .PKT_MAX  (64),
        .IDLE_CYC (20)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .clr      (clr),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .level    (level),
        .ovf_cnt  (ovf_cnt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record any handshake that completes on the coming edge, then step past it.
    task automatic cyc();
        if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
        @(posedge hclk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        s_tvalid = 1'b1;
        s_tdata  = d;
        cyc();
        s_tvalid = 1'b0;
    endtask

    int          bad_d;
    int          bad_l;
    int          bad_s;
    logic        hold;
    logic [7:0]  hd;
    logic        hl;
    logic [31:0] pat;

    initial begin
        hresetn  = 1'b0;
        clr      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        m_tready = 1'b0;
        repeat (3) cyc();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf_cnt, 0);
        hresetn = 1'b1;
        repeat (25) cyc();

        // single byte latency, then held byte gains tlast at idle timeout
        m_tready = 1'b1;
        wr(8'h55);
        chk("t1_lat1_tvalid", m_tvalid, 0);
        chk("t1_level", level, 1);
        cyc();
        chk("t1_lat2_tvalid", m_tvalid, 0);
        cyc();
        chk("t1_lat3_tvalid", m_tvalid, 1);
        chk("t1_tdata", m_tdata, 8'h55);
        chk("t1_tlast_early", m_tlast, 0);
        m_tready = 1'b0;
        repeat (17) cyc();
        chk("t1_tlast_pre_idle", m_tlast, 0);
        cyc();
        chk("t1_tlast_idle", m_tlast, 1);
        m_tready = 1'b1;
        cyc();
        chk("t1_popped", q.size(), 1);
        chk("t1_pop_val", q[0], 9'h155);
        chk("t1_level_end", level, 0);
        q.delete();

        // 130 back-to-back bytes, tail held until timeout
        for (int k = 1; k <= 130; k++) wr(8'(k));
        m_tready = 1'b0;
        chk("t2_level_held", level, 3);
        repeat (25) cyc();
        m_tready = 1'b1;
        repeat (6) cyc();
        chk("t2_count", q.size(), 130);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][7:0] != 8'(i + 1)) bad_d++;
            if (q[i][8] != ((i % 64 == 63) || (i == 129))) bad_l++;
        end
        chk("t2_data", bad_d, 0);
        chk("t2_tlast", bad_l, 0);
        q.delete();

        // fill to full, overflow three, drain all in order
        m_tready = 1'b0;
        for (int i = 0; i < 512; i++) wr(8'(i));
        for (int i = 0; i < 3; i++) wr(8'hEE);
        chk("t3_ovf", ovf_cnt, 3);
        chk("t3_level_full", level, 512);
        chk("t3_head", m_tdata, 0);
        m_tready = 1'b1;
        repeat (560) cyc();
        chk("t3_count", q.size(), 512);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][7:0] != 8'(i)) bad_d++;
            if (q[i][8] != (i % 64 == 63)) bad_l++;
        end
        chk("t3_data", bad_d, 0);
        chk("t3_tlast", bad_l, 0);
        chk("t3_level_end", level, 0);
        q.delete();

        // sync clear mid-packet
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) wr(8'h10 + 8'(i));
        chk("t6_level_pre", level, 20);
        chk("t6_ovf_pre", ovf_cnt, 3);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t6_clr_tvalid", m_tvalid, 0);
        chk("t6_clr_tdata", m_tdata, 0);
        chk("t6_clr_tlast", m_tlast, 0);
        chk("t6_clr_level", level, 0);
        chk("t6_clr_ovf", ovf_cnt, 0);
        m_tready = 1'b1;
        repeat (25) cyc();
        chk("t6_quiet", q.size(), 0);

        // flush of 10 bytes with a stalling consumer
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i));
        repeat (22) cyc();
        chk("t4_head", m_tdata, 8'hA0);
        chk("t4_head_tlast", m_tlast, 0);
        pat   = 32'b1001_1010_0110_0011_0101_1100_1010_0101;
        bad_s = 0;
        for (int c = 0; c < 100; c++) begin
            m_tready = pat[c % 32];
            hold = m_tvalid && !m_tready;
            hd   = m_tdata;
            hl   = m_tlast;
            cyc();
            if (hold && (!m_tvalid || m_tdata != hd || m_tlast != hl)) bad_s++;
        end
        chk("t4_stable", bad_s, 0);
        chk("t4_count", q.size(), 10);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][7:0] != 8'hA0 + 8'(i)) bad_d++;
            if (q[i][8] != (i == 9)) bad_l++;
        end
        chk("t4_data", bad_d, 0);
        chk("t4_tlast", bad_l, 0);
        q.delete();

        // timeout latch on the same edge as a pop
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i));
        repeat (19) cyc();
        chk("t5_level", level, 5);
        chk("t5_tlast_pre", m_tlast, 0);
        m_tready = 1'b1;
        repeat (11) cyc();
        chk("t5_count", q.size(), 5);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][7:0] != 8'hB0 + 8'(i)) bad_d++;
            if (q[i][8] != (i == 4)) bad_l++;
        end
        chk("t5_data", bad_d, 0);
        chk("t5_tlast", bad_l, 0);
        chk("t5_level_end", level, 0);
        q.delete();

        // asynchronous reset mid-packet, then normal operation resumes
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) wr(8'h30 + 8'(i));
        for (int i = 0; i < 3; i++) wr(8'h99);
        chk("t7_level_pre", level, 23);
        #2;
        hresetn = 1'b0;
        #1;
        chk("t7_arst_tvalid", m_tvalid, 0);
        chk("t7_arst_level", level, 0);
        chk("t7_arst_ovf", ovf_cnt, 0);
        cyc();
        hresetn = 1'b1;
        cyc();
        wr(8'h77);
        cyc();
        cyc();
        chk("t7_post_tvalid", m_tvalid, 1);
        chk("t7_post_tdata", m_tdata, 8'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
